// File: rtl/packet_pkg.sv
// Packet field widths and the packed packet word carried through the switch.
package packet_pkg;

  localparam int ADDR_WIDTH = 2;
  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] source;
    logic [ADDR_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

endpackage

// File: rtl/switch_egress_arb_if.sv
// Egress-stage bus: ingress request side, port output side and status.
interface switch_egress_arb_if
  import packet_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = packet_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = packet_pkg::DATA_WIDTH
);

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_source;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_target;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
  logic                            out_pause;
  logic                            valid_out;
  logic [ADDR_WIDTH-1:0]           source_out;
  logic [ADDR_WIDTH-1:0]           target_out;
  logic [DATA_WIDTH-1:0]           data_out;
  logic [$clog2(FIFO_DEPTH):0]     fifo_level;
  logic [7:0]                      misroute_cnt;

  modport slave (
    input  req_valid, req_source, req_target, req_data, out_pause,
    output req_ready, valid_out, source_out, target_out, data_out,
           fifo_level, misroute_cnt
  );

  modport master (
    output req_valid, req_source, req_target, req_data, out_pause,
    input  req_ready, valid_out, source_out, target_out, data_out,
           fifo_level, misroute_cnt
  );

endinterface

// File: rtl/switch_sync_fifo.sv
// Single-clock FIFO with occupancy counter; DEPTH must be a power of two >= 2.
module switch_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every variable gets a default before the conditionals so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: storage is not reset; the pointers and level alone decide which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/switch_egress_arb.sv
// Per-output-port egress stage: round-robin arbiter over all ingress paths,
// misroute filter and counter, egress FIFO and registered port output.
module switch_egress_arb
  import packet_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = packet_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = packet_pkg::DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_egress_arb_if.slave   bus
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR_WIDTH'(PORT_ID);

  logic [ADDR_WIDTH-1:0] src_a [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] tgt_a [NUM_PORTS];
  logic [DATA_WIDTH-1:0] dat_a [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign src_a[g] = bus.req_source[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign tgt_a[g] = bus.req_target[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_a[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]           mis_cnt_q, mis_cnt_d;
  logic                 valid_out_q;
  pkt_t                 out_pkt_q;

  logic [NUM_PORTS-1:0] grant;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     scan_idx;
  logic                 grant_any;

  logic                 fifo_full, fifo_empty;
  logic [LVL_W-1:0]     fifo_level;
  pkt_t                 in_pkt, fifo_head;
  logic                 xfer, misrouted, push, pop;

  // First requester at or after rr_ptr, wrapping around the ports.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (!grant_any && bus.req_valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
        grant_any       = 1'b1;
      end
    end
  end

  // Readiness is judged on the current level, so a same-edge pop never frees a slot.
  assign bus.req_ready = (rst || fifo_full) ? '0 : grant;
  assign xfer          = grant_any && !fifo_full;

  assign in_pkt.source = src_a[grant_idx];
  assign in_pkt.target = tgt_a[grant_idx];
  assign in_pkt.data   = dat_a[grant_idx];

  assign misrouted = (in_pkt.target != MY_ADDR);
  assign push      = xfer && !misrouted;
  assign pop       = !fifo_empty && !bus.out_pause;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    mis_cnt_d = mis_cnt_q;
    if (xfer) begin
      rr_ptr_d = PTR_W'((int'(grant_idx) + 1) % NUM_PORTS);
      if (misrouted && mis_cnt_q != 8'hFF) mis_cnt_d = mis_cnt_q + 8'd1;
    end
  end

  switch_sync_fifo #(
    .WIDTH ($bits(pkt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_pkt),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Output fields hold their last value between pops; valid_out is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      mis_cnt_q   <= '0;
      valid_out_q <= 1'b0;
      out_pkt_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mis_cnt_q   <= mis_cnt_d;
      valid_out_q <= pop;
      if (pop) out_pkt_q <= fifo_head;
    end
  end

  assign bus.valid_out    = valid_out_q;
  assign bus.source_out   = out_pkt_q.source;
  assign bus.target_out   = out_pkt_q.target;
  assign bus.data_out     = out_pkt_q.data;
  assign bus.fifo_level   = fifo_level;
  assign bus.misroute_cnt = mis_cnt_q;

endmodule

// File: tb/tb_switch_egress_arb.sv
// Bench for switch_egress_arb: directed scenarios plus randomized traffic
// checked against a queue-based packet model.
module tb_switch_egress_arb;
  import packet_pkg::*;

  localparam int NP    = 4;
  localparam int DEPTH = 4;
  localparam int PORT  = 0;
  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_egress_arb_if #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  switch_egress_arb #(
    .NUM_PORTS (NP), .PORT_ID (PORT), .FIFO_DEPTH (DEPTH), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Ingress stimulus state
  logic [NP-1:0] v;
  pkt_t          cur [NP];
  logic          pause;

  // Reference model
  pkt_t mq [$];
  int   m_rr;
  int   m_mis;
  logic m_valid;
  pkt_t m_out;

  function automatic pkt_t mk(int s, int t, int d);
    pkt_t p;
    p.source = AW'(s);
    p.target = AW'(t);
    p.data   = DW'(d);
    return p;
  endfunction

  function automatic pkt_t obs();
    pkt_t p;
    p.source = bus.source_out;
    p.target = bus.target_out;
    p.data   = bus.data_out;
    return p;
  endfunction

  task automatic drive();
    bus.req_valid = v;
    bus.out_pause = pause;
    for (int i = 0; i < NP; i++) begin
      bus.req_source[i*AW +: AW] = cur[i].source;
      bus.req_target[i*AW +: AW] = cur[i].target;
      bus.req_data[i*DW +: DW]   = cur[i].data;
    end
  endtask

  // Which ingress the arbitration rules say should be accepted this cycle.
  function automatic logic [NP-1:0] model_ready();
    logic [NP-1:0] r;
    int idx;
    r = '0;
    if (mq.size() >= DEPTH) return r;
    for (int k = 0; k < NP; k++) begin
      idx = (m_rr + k) % NP;
      if (v[idx]) begin
        r[idx] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rr    = 0;
    m_mis   = 0;
    m_valid = 1'b0;
    m_out   = '0;
    v       = '0;
    pause   = 1'b0;
    for (int i = 0; i < NP; i++) cur[i] = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    model_reset();
    drive();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive, sample ready, advance the model over the edge, return at negedge.
  task automatic tick(output logic [NP-1:0] o, output logic [NP-1:0] e);
    int   acc;
    pkt_t head;
    bit   do_pop;
    drive();
    #1;
    o   = bus.req_ready;
    e   = model_ready();
    acc = -1;
    for (int i = 0; i < NP; i++) if (e[i]) acc = i;
    @(posedge clk);
    do_pop = (mq.size() > 0) && !pause;
    head   = '0;
    if (do_pop) head = mq.pop_front();
    if (acc >= 0) begin
      if (int'(cur[acc].target) == PORT) mq.push_back(cur[acc]);
      else if (m_mis < 255) m_mis++;
      m_rr = (acc + 1) % NP;
    end
    m_valid = do_pop;
    if (do_pop) m_out = head;
    v = v & ~o;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    v = 4'b0100;
    cur[2] = mk(2, 0, 'hA5);
    drive();
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
    checks++; if (obs() !== pkt_t'('0)) begin failures++; $display("FAIL reset_fields got=%h exp=0", obs()); end
    checks++; if (int'(bus.fifo_level) !== 0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level); end
    checks++; if (bus.misroute_cnt !== 8'd0) begin failures++; $display("FAIL reset_miscnt got=%0d exp=0", bus.misroute_cnt); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [NP-1:0] o, e;
    v = 4'b0100;
    cur[2] = mk(2, 0, 'hA5);
    tick(o, e);
    checks++; if (o !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", o); end
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", bus.valid_out); end
    checks++; if (int'(bus.fifo_level) !== 1) begin failures++; $display("FAIL single_level1 got=%0d exp=1", bus.fifo_level); end
    tick(o, e);
    checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.valid_out); end
    checks++; if (obs() !== mk(2, 0, 'hA5)) begin failures++; $display("FAIL single_pkt got=%h exp=%h", obs(), mk(2, 0, 'hA5)); end
    checks++; if (int'(bus.fifo_level) !== 0) begin failures++; $display("FAIL single_level0 got=%0d exp=0", bus.fifo_level); end
    tick(o, e);
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL single_pulse got=%b exp=0", bus.valid_out); end
    checks++; if (obs() !== mk(2, 0, 'hA5)) begin failures++; $display("FAIL single_hold got=%h exp=%h", obs(), mk(2, 0, 'hA5)); end
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] o, e, exp_r;
    int got [$];
    reset_dut();
    for (int i = 0; i < NP; i++) cur[i] = mk(i, 0, $urandom);
    v = '1;
    for (int c = 0; c < 16; c++) begin
      tick(o, e);
      exp_r = '0;
      exp_r[c % NP] = 1'b1;
      checks++; if (o !== exp_r) begin failures++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, o, exp_r); end
      for (int i = 0; i < NP; i++) if (o[i]) begin cur[i] = mk(i, 0, $urandom); v[i] = 1'b1; end
      if (bus.valid_out) got.push_back(int'(bus.source_out));
    end
    v = '0;
    for (int c = 0; c < 3; c++) begin
      tick(o, e);
      if (bus.valid_out) got.push_back(int'(bus.source_out));
    end
    checks++; if (got.size() !== 16) begin failures++; $display("FAIL rr_emit_count got=%0d exp=16", got.size()); end
    for (int n = 0; n < got.size(); n++) begin
      checks++; if (got[n] !== n % NP) begin failures++; $display("FAIL rr_emit_order idx=%0d got=%0d exp=%0d", n, got[n], n % NP); end
    end
  endtask

  task automatic test_pause_full();
    logic [NP-1:0] o, e;
    int sent, pulses;
    logic vs [10];
    int got [$];
    sent   = 0;
    pulses = 0;
    pause  = 1'b1;
    cur[1] = mk(1, 0, 'h30);
    v      = 4'b0010;
    for (int t = 0; t < 6; t++) begin
      tick(o, e);
      if (bus.valid_out) pulses++;
      if (o[1]) begin
        sent++;
        if (sent < 6) begin cur[1] = mk(1, 0, 'h30 + sent); v[1] = 1'b1; end
      end
    end
    checks++; if (sent !== 4) begin failures++; $display("FAIL pause_accepts got=%0d exp=4", sent); end
    checks++; if (int'(bus.fifo_level) !== 4) begin failures++; $display("FAIL pause_level got=%0d exp=4", bus.fifo_level); end
    checks++; if (o !== 4'b0000) begin failures++; $display("FAIL full_ready got=%b exp=0000", o); end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL pause_emitted got=%0d exp=0", pulses); end
    pause = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick(o, e);
      vs[t] = bus.valid_out;
      if (bus.valid_out) got.push_back(int'(bus.data_out));
      if (o[1]) begin
        sent++;
        if (sent < 6) begin cur[1] = mk(1, 0, 'h30 + sent); v[1] = 1'b1; end
      end
    end
    checks++; if ({vs[0], vs[1], vs[2], vs[3]} !== 4'b1111) begin failures++; $display("FAIL release_burst got=%b%b%b%b exp=1111", vs[0], vs[1], vs[2], vs[3]); end
    checks++; if (sent !== 6) begin failures++; $display("FAIL release_accepts got=%0d exp=6", sent); end
    checks++; if (got.size() !== 6) begin failures++; $display("FAIL release_emits got=%0d exp=6", got.size()); end
    for (int n = 0; n < got.size(); n++) begin
      checks++; if (got[n] !== 'h30 + n) begin failures++; $display("FAIL release_order idx=%0d got=%h exp=%h", n, got[n], 'h30 + n); end
    end
  endtask

  task automatic test_misroute();
    logic [NP-1:0] o, e;
    int emitted;
    emitted = 0;
    reset_dut();
    cur[3] = mk(3, 2, 'h5A);
    v = 4'b1000;
    tick(o, e);
    checks++; if (o !== 4'b1000) begin failures++; $display("FAIL mis_ready got=%b exp=1000", o); end
    checks++; if (int'(bus.fifo_level) !== 0) begin failures++; $display("FAIL mis_level got=%0d exp=0", bus.fifo_level); end
    checks++; if (bus.misroute_cnt !== 8'd1) begin failures++; $display("FAIL mis_cnt1 got=%0d exp=1", bus.misroute_cnt); end
    for (int n = 2; n <= 300; n++) begin
      v[3] = 1'b1;
      tick(o, e);
      if (bus.valid_out) emitted++;
      if (n == 100) begin
        checks++; if (bus.misroute_cnt !== 8'd100) begin failures++; $display("FAIL mis_cnt100 got=%0d exp=100", bus.misroute_cnt); end
      end
    end
    v = '0;
    checks++; if (bus.misroute_cnt !== 8'd255) begin failures++; $display("FAIL mis_saturate got=%0d exp=255", bus.misroute_cnt); end
    checks++; if (emitted !== 0) begin failures++; $display("FAIL mis_emitted got=%0d exp=0", emitted); end
  endtask

  task automatic test_push_pop_same_edge();
    logic [NP-1:0] o, e;
    int got [$];
    reset_dut();
    pause  = 1'b1;
    cur[0] = mk(0, 0, 'h71); v = 4'b0001;
    tick(o, e);
    cur[0] = mk(0, 0, 'h72); v[0] = 1'b1;
    tick(o, e);
    checks++; if (int'(bus.fifo_level) !== 2) begin failures++; $display("FAIL pp_level_pre got=%0d exp=2", bus.fifo_level); end
    pause  = 1'b0;
    cur[0] = mk(0, 0, 'h73); v[0] = 1'b1;
    tick(o, e);
    checks++; if (o !== 4'b0001) begin failures++; $display("FAIL pp_ready got=%b exp=0001", o); end
    checks++; if (int'(bus.fifo_level) !== 2) begin failures++; $display("FAIL pp_level_same got=%0d exp=2", bus.fifo_level); end
    if (bus.valid_out) got.push_back(int'(bus.data_out));
    v = '0;
    for (int t = 0; t < 3; t++) begin
      tick(o, e);
      if (bus.valid_out) got.push_back(int'(bus.data_out));
    end
    checks++; if (got.size() !== 3) begin failures++; $display("FAIL pp_count got=%0d exp=3", got.size()); end
    for (int n = 0; n < got.size(); n++) begin
      checks++; if (got[n] !== 'h71 + n) begin failures++; $display("FAIL pp_order idx=%0d got=%h exp=%h", n, got[n], 'h71 + n); end
    end
  endtask

  task automatic test_random();
    logic [NP-1:0] o, e;
    for (int c = 0; c < 600; c++) begin
      pause = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NP; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          cur[i] = mk(i, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : PORT, $urandom);
          v[i]   = 1'b1;
        end
      end
      tick(o, e);
      checks++; if (o !== e) begin failures++; $display("FAIL rnd_ready cycle=%0d got=%b exp=%b", c, o, e); end
      checks++; if (bus.valid_out !== m_valid) begin failures++; $display("FAIL rnd_valid cycle=%0d got=%b exp=%b", c, bus.valid_out, m_valid); end
      checks++; if (obs() !== m_out) begin failures++; $display("FAIL rnd_pkt cycle=%0d got=%h exp=%h", c, obs(), m_out); end
      checks++; if (int'(bus.fifo_level) !== mq.size()) begin failures++; $display("FAIL rnd_level cycle=%0d got=%0d exp=%0d", c, bus.fifo_level, mq.size()); end
      checks++; if (int'(bus.misroute_cnt) !== m_mis) begin failures++; $display("FAIL rnd_miscnt cycle=%0d got=%0d exp=%0d", c, bus.misroute_cnt, m_mis); end
    end
  endtask

  task automatic test_reset_mid();
    logic [NP-1:0] o, e;
    int stale;
    stale = 0;
    reset_dut();
    pause = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cur[0] = mk(0, 0, 'h81 + n);
      v[0]   = 1'b1;
      tick(o, e);
    end
    pause = 1'b0;
    v     = '0;
    tick(o, e);
    checks++; if (bus.valid_out !== 1'b1 || int'(bus.fifo_level) !== 3) begin failures++; $display("FAIL mid_setup valid=%b level=%0d exp valid=1 level=3", bus.valid_out, bus.fifo_level); end
    rst = 1'b1;
    v   = 4'b0110;
    drive();
    #1;
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.valid_out); end
    checks++; if (obs() !== pkt_t'('0)) begin failures++; $display("FAIL mid_fields got=%h exp=0", obs()); end
    checks++; if (int'(bus.fifo_level) !== 0) begin failures++; $display("FAIL mid_level got=%0d exp=0", bus.fifo_level); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready got=%b exp=0000", bus.req_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int t = 0; t < 5; t++) begin
      tick(o, e);
      if (bus.valid_out) stale++;
    end
    checks++; if (stale !== 0) begin failures++; $display("FAIL mid_stale got=%0d exp=0", stale); end
    for (int i = 0; i < NP; i++) cur[i] = mk(i, 0, i);
    v = '1;
    tick(o, e);
    checks++; if (o !== 4'b0001) begin failures++; $display("FAIL mid_rr_restart got=%b exp=0001", o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pause_full();
    test_misroute();
    test_push_pop_same_edge();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
